// File: rtl/camera_capture.sv
`default_nettype none
// ============================================================================
// Module  : camera_capture
// Brief   : Captures RGB565 camera bytes into an RGB332 frame buffer write port.
// Revision: 1.0
// ============================================================================
module camera_capture #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        DATA,
    output logic [7:0]        PIXEL_DATA,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              DROP
);

    // Counters reach exactly the window size and stick there, so an
    // out-of-window position can never alias onto a valid address.
    localparam int X_W = $clog2(SCREEN_WIDTH + 1);
    localparam int Y_W = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [X_W-1:0]    X_LIMIT     = X_W'(SCREEN_WIDTH);
    localparam logic [Y_W-1:0]    Y_LIMIT     = Y_W'(SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(SCREEN_WIDTH);

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        VBLANK = 3'd1,
        HBLANK = 3'd2,
        PIX_HI = 3'd3,
        PIX_LO = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [5:0]        hi_q, hi_d;
    logic [7:0]        pixel_q, pixel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;

    logic              in_window;
    logic [ADDR_W-1:0] pix_addr;
    logic [X_W-1:0]    x_inc;
    logic [Y_W-1:0]    y_inc;

    assign in_window = (x_q < X_LIMIT) && (y_q < Y_LIMIT);
    assign pix_addr  = ADDR_W'(x_q) + (ADDR_W'(y_q) * LINE_STRIDE);
    assign x_inc     = (x_q == X_LIMIT) ? x_q : x_q + 1'b1;
    assign y_inc     = (y_q == Y_LIMIT) ? y_q : y_q + 1'b1;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        pixel_d = pixel_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        done_d  = 1'b0;
        drop_d  = drop_q;

        case (state_q)
            SYNC: begin
                if (VSYNC) begin
                    state_d = VBLANK;
                end
            end
            VBLANK: begin
                if (!VSYNC) begin
                    state_d = HBLANK;
                    x_d     = '0;
                    y_d     = '0;
                    drop_d  = 1'b0;
                end
            end
            HBLANK, PIX_HI: begin
                if (VSYNC) begin
                    state_d = VBLANK;
                    done_d  = 1'b1;
                end else if (HREF) begin
                    // Only R[4:2] and G[5:3] of the high byte survive conversion.
                    hi_d    = {DATA[7:5], DATA[2:0]};
                    state_d = PIX_LO;
                end else if (state_q == PIX_HI) begin
                    state_d = HBLANK;
                    x_d     = '0;
                    y_d     = y_inc;
                end
            end
            PIX_LO: begin
                if (VSYNC) begin
                    state_d = VBLANK;
                    done_d  = 1'b1;
                end else if (HREF) begin
                    state_d = PIX_HI;
                    x_d     = x_inc;
                    if (in_window) begin
                        pixel_d = {hi_q, DATA[4:3]};
                        addr_d  = pix_addr;
                        wen_d   = 1'b1;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else begin
                    // Line ended mid-pixel: the stored high byte is discarded.
                    state_d = HBLANK;
                    x_d     = '0;
                    y_d     = y_inc;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= SYNC;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            pixel_q <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            pixel_q <= pixel_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign PIXEL_DATA = pixel_q;
    assign W_ADDR     = addr_q;
    assign W_EN       = wen_q;
    assign FRAME_DONE = done_q;
    assign DROP       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_camera_capture
// Brief   : Directed self-checking bench for camera_capture.
// Revision: 1.0
// ============================================================================
module tb_camera_capture;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;
    logic        VSYNC = 1'b0;
    logic        HREF  = 1'b0;
    logic [7:0]  DATA  = 8'h00;
    logic [7:0]  PIXEL_DATA;
    logic [14:0] W_ADDR;
    logic        W_EN;
    logic        FRAME_DONE;
    logic        DROP;

    camera_capture #(
        .SCREEN_WIDTH (176),
        .SCREEN_HEIGHT(144),
        .ADDR_W       (15)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .VSYNC     (VSYNC),
        .HREF      (HREF),
        .DATA      (DATA),
        .PIXEL_DATA(PIXEL_DATA),
        .W_ADDR    (W_ADDR),
        .W_EN      (W_EN),
        .FRAME_DONE(FRAME_DONE),
        .DROP      (DROP)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write / frame-done activity log, sampled on the falling edge.
    int          wr_count     = 0;
    int          done_count   = 0;
    int          wen_run_err  = 0;
    int          done_run_err = 0;
    logic [31:0] last_addr    = 0;
    logic [31:0] last_pix     = 0;
    logic [31:0] max_addr     = 0;
    logic        wen_prev     = 1'b0;
    logic        done_prev    = 1'b0;

    always @(negedge CLK) begin
        if (W_EN === 1'b1) begin
            wr_count  <= wr_count + 1;
            last_addr <= 32'(W_ADDR);
            last_pix  <= 32'(PIXEL_DATA);
            if (32'(W_ADDR) > max_addr) max_addr <= 32'(W_ADDR);
            if (wen_prev) wen_run_err <= wen_run_err + 1;
        end
        if (FRAME_DONE === 1'b1) begin
            done_count <= done_count + 1;
            if (done_prev) done_run_err <= done_run_err + 1;
        end
        wen_prev  <= (W_EN === 1'b1);
        done_prev <= (FRAME_DONE === 1'b1);
    end

    task automatic clear_log();
        @(posedge CLK);
        #1;
        wr_count     = 0;
        done_count   = 0;
        wen_run_err  = 0;
        done_run_err = 0;
        last_addr    = 0;
        last_pix     = 0;
        max_addr     = 0;
    endtask

    // Outputs seen at the falling edge just before new inputs are applied.
    logic        s_wen;
    logic        s_done;
    logic [14:0] s_addr;
    logic [7:0]  s_pix;

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge CLK);
        s_wen  = W_EN;
        s_done = FRAME_DONE;
        s_addr = W_ADDR;
        s_pix  = PIXEL_DATA;
        VSYNC  = vs;
        HREF   = hr;
        DATA   = d;
    endtask

    task automatic start_frame();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic end_frame();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int nbytes);
        for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, 8'(i * 37));
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"},  32'(W_EN), 0);
        check({tag, "_done"}, 32'(FRAME_DONE), 0);
        check({tag, "_drop"}, 32'(DROP), 0);
        check({tag, "_pix"},  32'(PIXEL_DATA), 0);
        check({tag, "_addr"}, 32'(W_ADDR), 0);
    endtask

    logic [7:0] colour_bytes [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    logic [7:0] colour_exp   [4] = '{8'hE0, 8'h1C, 8'h03, 8'hFF};

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b1;
        clear_log();

        // Colour conversion and write latency
        start_frame();
        check("sync_no_done", 32'(done_count), 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, colour_bytes[i]);
            if (i >= 1 && ((i - 1) % 2) == 1) begin
                check($sformatf("colour_wen%0d", i), 32'(s_wen), 1);
                check($sformatf("colour_addr%0d", i), 32'(s_addr), 32'((i - 1) / 2));
                check($sformatf("colour_pix%0d", i), 32'(s_pix), 32'(colour_exp[(i - 1) / 2]));
            end else begin
                check($sformatf("colour_idle%0d", i), 32'(s_wen), 0);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        check("colour_wen7", 32'(s_wen), 1);
        check("colour_addr7", 32'(s_addr), 3);
        check("colour_pix7", 32'(s_pix), 32'h FF);
        drive(1'b0, 1'b0, 8'h00);
        check("hold_wen", 32'(s_wen), 0);
        check("hold_addr", 32'(s_addr), 3);
        check("hold_pix", 32'(s_pix), 32'hFF);

        // Addressing across lines
        end_frame();
        start_frame();
        clear_log();
        repeat (3) send_line(352);
        send_line(8);
        check("addr_count", 32'(wr_count), 532);
        check("addr_last", last_addr, 531);
        check("addr_wen_runs", 32'(wen_run_err), 0);

        // Overflow in X
        end_frame();
        start_frame();
        clear_log();
        send_line(360);
        check("ovx_count", 32'(wr_count), 176);
        check("ovx_max", max_addr, 175);
        check("ovx_drop", 32'(DROP), 1);
        end_frame();
        check("ovx_drop_vsync", 32'(DROP), 1);
        start_frame();
        check("ovx_drop_clear", 32'(DROP), 0);

        // Overflow in Y
        clear_log();
        repeat (150) send_line(4);
        check("ovy_count", 32'(wr_count), 288);
        check("ovy_max", max_addr, 1 + 143 * 176);
        check("ovy_drop", 32'(DROP), 1);
        end_frame();
        start_frame();
        check("ovy_drop_clear", 32'(DROP), 0);

        // Partial pixel at end of line
        clear_log();
        send_line(5);
        check("part_count", 32'(wr_count), 2);
        check("part_last", last_addr, 1);
        send_line(2);
        check("part_next_count", 32'(wr_count), 3);
        check("part_next_addr", last_addr, 176);

        // Premature VSYNC in PIX_LO
        end_frame();
        start_frame();
        clear_log();
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'hF8);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        check("pvs_done_hi", 32'(s_done), 1);
        check("pvs_no_wen", 32'(s_wen), 0);
        drive(1'b1, 1'b0, 8'h00);
        check("pvs_done_lo", 32'(s_done), 0);
        drive(1'b1, 1'b0, 8'h00);
        check("pvs_count", 32'(wr_count), 1);
        check("pvs_done_count", 32'(done_count), 1);
        check("pvs_done_runs", 32'(done_run_err), 0);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        send_line(2);
        check("pvs_restart_count", 32'(wr_count), 2);
        check("pvs_restart_addr", last_addr, 0);

        // Reset during line 10
        end_frame();
        start_frame();
        repeat (10) send_line(4);
        drive(1'b0, 1'b1, 8'hF8);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'hF8);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_all_zero("midrst");
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        drive(1'b0, 1'b1, 8'h33);
        check_all_zero("midrst_hold");
        @(negedge CLK);
        RESET = 1'b1;
        HREF  = 1'b0;
        clear_log();
        send_line(6);
        check("rst_no_write", 32'(wr_count), 0);
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        check("rst_no_done", 32'(done_count), 0);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        send_line(2);
        check("rst_first_count", 32'(wr_count), 1);
        check("rst_first_addr", last_addr, 0);
        check("rst_done_after", 32'(done_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
